// File: rtl/bt_status_pio_in_pkg.sv
// Shared definitions for the Bluetooth status input PIO: register map,
// edge-selection encodings and bus widths.
package bt_pio_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 2;

  // Avalon register map (word addresses).
  typedef enum logic [ADDR_W-1:0] {
    ADDR_DATA    = 2'd0,
    ADDR_DIR     = 2'd1,
    ADDR_IRQMASK = 2'd2,
    ADDR_EDGECAP = 2'd3
  } reg_addr_e;

  // Which filtered-level transition sets an edgecapture bit.
  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // Debounce counter width; never zero so the declaration stays legal
  // even when the filter is bypassed.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bt_status_pio_in_if.sv
// Avalon-MM slave bus bundle for the status input PIO.
interface bt_status_pio_in_if;
  import bt_pio_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              read_n;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (
    output address, chipselect, read_n, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read_n, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/bt_pio_debounce_bit.sv
// One status pin: two-flop synchroniser followed by a stability filter.
// The filtered level only follows the synchronised pin after it has
// differed for DEBOUNCE_CYCLES consecutive clocks; 0 bypasses the filter.
module bt_pio_debounce_bit
  import bt_pio_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter logic RESET_BIT       = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_i,
  output logic filtered_o
);

  logic sync1_q, sync2_q;

  // Synchroniser: bring the asynchronous pin into the clk domain.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // its pre-edge input; sync2_q gets the old sync1_q, not the new pin value.
    if (reset) begin
      sync1_q <= RESET_BIT;
      sync2_q <= RESET_BIT;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign filtered_o = sync2_q;
    end else begin : g_filter
      localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
      localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] cnt_q, cnt_d;
      logic          filt_q, filt_d;

      // Count consecutive disagreeing cycles; flip the level on the last one.
      always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves it unassigned and no latch is inferred.
        cnt_d  = '0;
        filt_d = filt_q;
        if (sync2_q != filt_q) begin
          if (cnt_q == CNT_LAST) begin
            filt_d = sync2_q;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      // Filter state; reset discards any partially counted excursion.
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_q  <= '0;
          filt_q <= RESET_BIT;
        end else begin
          cnt_q  <= cnt_d;
          filt_q <= filt_d;
        end
      end

      assign filtered_o = filt_q;
    end
  endgenerate

endmodule

// File: rtl/bt_status_pio_in.sv
// Avalon-MM input PIO for the Bluetooth module status pins. Each pin is
// synchronised and debounced, transitions of the filtered level are latched
// in a write-1-to-clear edgecapture register, and a masked OR of the captured
// bits drives a registered level interrupt.
module bt_status_pio_in
  import bt_pio_pkg::*;
#(
  parameter int               WIDTH           = 2,
  parameter int               EDGE_TYPE       = EDGE_RISING,
  parameter int               DEBOUNCE_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic               clk,
  input  logic               reset,
  bt_status_pio_in_if.slave  bus,
  input  logic [WIDTH-1:0]   in_port,
  output logic               irq
);

  logic [WIDTH-1:0]  filtered;
  logic [WIDTH-1:0]  filtered_dly_q;
  logic [WIDTH-1:0]  edge_evt;
  logic [WIDTH-1:0]  clr_mask;
  logic [WIDTH-1:0]  wdata_w;
  logic [WIDTH-1:0]  edgecap_q, edgecap_d;
  logic [WIDTH-1:0]  irqmask_q, irqmask_d;
  logic [DATA_W-1:0] readdata_q, readdata_d;
  logic              irq_q, irq_d;
  logic              rd_en, wr_en;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    bt_pio_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_BIT       (RESET_VALUE[i])
    ) u_debounce (
      .clk        (clk),
      .reset      (reset),
      .pin_i      (in_port[i]),
      .filtered_o (filtered[i])
    );
  end

  // Upper write-data bits have no destination when fewer than 32 pins exist.
  if (WIDTH < DATA_W) begin : g_wdata_unused
    logic unused_wdata;
    assign unused_wdata = ^bus.writedata[DATA_W-1:WIDTH];
  end

  assign rd_en   = bus.chipselect & ~bus.read_n;
  assign wr_en   = bus.chipselect & ~bus.write_n;
  assign wdata_w = bus.writedata[WIDTH-1:0];

  // Next-state for edge capture, mask, interrupt and read data.
  always_comb begin
    unique case (EDGE_TYPE)
      EDGE_FALLING: edge_evt = ~filtered & filtered_dly_q;
      EDGE_ANY:     edge_evt =  filtered ^ filtered_dly_q;
      default:      edge_evt =  filtered & ~filtered_dly_q;
    endcase

    clr_mask  = (wr_en && bus.address == ADDR_EDGECAP) ? wdata_w : '0;
    // A capture on the same edge as its clear wins, so no event is lost.
    edgecap_d = (edgecap_q & ~clr_mask) | edge_evt;
    irqmask_d = (wr_en && bus.address == ADDR_IRQMASK) ? wdata_w : irqmask_q;
    // Built from next-state values so irq rises on the same edge as the
    // capture or unmask that causes it, while still coming from a flop.
    irq_d     = |(edgecap_d & irqmask_d);

    // Reads see current register contents, i.e. the pre-write value.
    readdata_d = '0;
    if (rd_en) begin
      unique case (reg_addr_e'(bus.address))
        ADDR_DATA:    readdata_d = DATA_W'(filtered);
        ADDR_IRQMASK: readdata_d = DATA_W'(irqmask_q);
        ADDR_EDGECAP: readdata_d = DATA_W'(edgecap_q);
        default:      readdata_d = '0;
      endcase
    end
  end

  // Register state; filtered_dly_q resets to the filter reset level so no
  // spurious edge is seen when reset releases.
  always_ff @(posedge clk) begin
    if (reset) begin
      filtered_dly_q <= RESET_VALUE;
      edgecap_q      <= '0;
      irqmask_q      <= '0;
      readdata_q     <= '0;
      irq_q          <= 1'b0;
    end else begin
      filtered_dly_q <= filtered;
      edgecap_q      <= edgecap_d;
      irqmask_q      <= irqmask_d;
      readdata_q     <= readdata_d;
      irq_q          <= irq_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_bt_status_pio_in.sv
// Self-checking bench for bt_status_pio_in. Two instances: A uses the
// defaults (rising edge, 4-cycle debounce), B captures any edge with the
// filter bypassed. A cycle-level reference model tracks both.
module tb_bt_status_pio_in;

  logic clk;
  logic reset;
  logic [1:0] pin_a, pin_b;
  logic irq_a, irq_b;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  // Bus drive variables, index 0 = instance A, 1 = instance B.
  logic [1:0]  addr_v [2];
  logic        cs_v   [2];
  logic        rn_v   [2];
  logic        wn_v   [2];
  logic [31:0] wd_v   [2];

  bt_status_pio_in_if bus_a ();
  bt_status_pio_in_if bus_b ();

  assign bus_a.address    = addr_v[0];
  assign bus_a.chipselect = cs_v[0];
  assign bus_a.read_n     = rn_v[0];
  assign bus_a.write_n    = wn_v[0];
  assign bus_a.writedata  = wd_v[0];
  assign bus_b.address    = addr_v[1];
  assign bus_b.chipselect = cs_v[1];
  assign bus_b.read_n     = rn_v[1];
  assign bus_b.write_n    = wn_v[1];
  assign bus_b.writedata  = wd_v[1];

  bt_status_pio_in #(
    .WIDTH (2), .EDGE_TYPE (0), .DEBOUNCE_CYCLES (4), .RESET_VALUE (2'b00)
  ) dut_a (
    .clk (clk), .reset (reset), .bus (bus_a), .in_port (pin_a), .irq (irq_a)
  );

  bt_status_pio_in #(
    .WIDTH (2), .EDGE_TYPE (2), .DEBOUNCE_CYCLES (0), .RESET_VALUE (2'b00)
  ) dut_b (
    .clk (clk), .reset (reset), .bus (bus_b), .in_port (pin_b), .irq (irq_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------
  // Reference model. hist[k] is the pin value sampled k+1 edges ago.
  // The filtered level flips once the synchronised pin has held the
  // opposite value over the last N samples it presented.
  // ---------------------------------------------------------------------
  typedef struct packed {
    logic [5:0][31:0] hist;
    logic [31:0]      filt;
    logic [31:0]      fprev;
    logic [31:0]      ecap;
    logic [31:0]      mask;
    logic [31:0]      rd;
    logic             irq;
  } mst_t;

  mst_t ma, mb;

  function automatic mst_t step(input mst_t s, input logic rst,
                                input logic [1:0] a, input logic cs,
                                input logic rn, input logic wn,
                                input logic [31:0] wd, input logic [31:0] pins,
                                input int n, input int et, input logic [31:0] wm);
    mst_t        o;
    logic [31:0] ev, clr;
    logic        wr, flip;
    o = s;
    if (rst) begin
      for (int k = 0; k < 6; k++) o.hist[k] = '0;
      o.filt = '0; o.fprev = '0; o.ecap = '0; o.mask = '0; o.rd = '0; o.irq = 1'b0;
      return o;
    end
    o.rd = '0;
    if (cs && !rn) begin
      case (a)
        2'd0:    o.rd = s.filt;
        2'd2:    o.rd = s.mask;
        2'd3:    o.rd = s.ecap;
        default: o.rd = '0;
      endcase
    end
    wr  = cs && !wn;
    clr = (wr && a == 2'd3) ? (wd & wm) : '0;
    if (et == 0)      ev = s.filt & ~s.fprev;
    else if (et == 1) ev = ~s.filt & s.fprev;
    else              ev = s.filt ^ s.fprev;
    o.ecap  = (s.ecap & ~clr) | ev;
    o.mask  = (wr && a == 2'd2) ? (wd & wm) : s.mask;
    o.fprev = s.filt;
    if (n == 0) begin
      o.filt = s.hist[0];
    end else begin
      for (int b = 0; b < 32; b++) begin
        flip = wm[b];
        for (int k = 1; k <= n; k++)
          if (s.hist[k][b] == s.filt[b]) flip = 1'b0;
        if (flip) o.filt[b] = ~s.filt[b];
      end
    end
    for (int k = 5; k > 0; k--) o.hist[k] = s.hist[k-1];
    o.hist[0] = pins & wm;
    o.irq = |(o.ecap & o.mask);
    return o;
  endfunction

  always @(posedge clk) begin
    ma = step(ma, reset, bus_a.address, bus_a.chipselect, bus_a.read_n,
              bus_a.write_n, bus_a.writedata, {30'b0, pin_a}, 4, 0, 32'h3);
    mb = step(mb, reset, bus_b.address, bus_b.chipselect, bus_b.read_n,
              bus_b.write_n, bus_b.writedata, {30'b0, pin_b}, 0, 2, 32'h3);
  end

  // ---------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle, both instances' outputs must match the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_a_readdata", bus_a.readdata, ma.rd);
      check("model_a_irq", {31'b0, irq_a}, {31'b0, ma.irq});
      check("model_b_readdata", bus_b.readdata, mb.rd);
      check("model_b_irq", {31'b0, irq_b}, {31'b0, mb.irq});
    end
  end

  // ---------------------------------------------------------------------
  // Bus tasks: start and end on a falling edge.
  // ---------------------------------------------------------------------
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic bus_wr(input int u, input logic [1:0] a, input logic [31:0] d);
    addr_v[u] = a; wd_v[u] = d; cs_v[u] = 1'b1; wn_v[u] = 1'b0;
    cycle();
    cs_v[u] = 1'b0; wn_v[u] = 1'b1;
  endtask

  task automatic rd_chk(input int u, input logic [1:0] a, input logic [31:0] exp,
                        input string name);
    logic [31:0] d;
    addr_v[u] = a; cs_v[u] = 1'b1; rn_v[u] = 1'b0;
    cycle();
    d = (u == 0) ? bus_a.readdata : bus_b.readdata;
    cs_v[u] = 1'b0; rn_v[u] = 1'b1;
    check(name, d, exp);
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    reset = 1'b1;
    pin_a = 2'b00;
    pin_b = 2'b00;
    for (int u = 0; u < 2; u++) begin
      addr_v[u] = '0; cs_v[u] = 1'b0; rn_v[u] = 1'b1; wn_v[u] = 1'b1; wd_v[u] = '0;
    end
    @(posedge clk);
    @(negedge clk);
    cmp_en = 1'b1;
    idle(2);
    check("reset_readdata_a", bus_a.readdata, 32'h0);
    check("reset_irq_a", {31'b0, irq_a}, 32'h0);
    reset = 1'b0;
    rd_chk(0, 2'd0, 32'h0, "reset_data");
    rd_chk(0, 2'd2, 32'h0, "reset_irqmask");
    rd_chk(0, 2'd3, 32'h0, "reset_edgecap");

    // 1: rising edge on bit 0 captured exactly 7 edges after the change.
    //    Read k returns edgecapture as it stood after edge k-1.
    pin_a = 2'b01;
    for (int k = 1; k <= 8; k++) begin
      rd_chk(0, 2'd3, (k == 8) ? 32'h1 : 32'h0, $sformatf("t1_edgecap_k%0d", k));
      check("t1_irq_masked_off", {31'b0, irq_a}, 32'h0);
    end
    rd_chk(0, 2'd0, 32'h1, "t1_data");

    // 2: masked-in capture raises irq on the capture edge; W1C drops it.
    bus_wr(0, 2'd3, 32'h3);
    pin_a = 2'b00;
    idle(8);
    bus_wr(0, 2'd2, 32'h1);
    check("t2_irq_before", {31'b0, irq_a}, 32'h0);
    pin_a = 2'b01;
    for (int k = 1; k <= 7; k++) begin
      cycle();
      check($sformatf("t2_irq_k%0d", k), {31'b0, irq_a}, (k >= 7) ? 32'h1 : 32'h0);
    end
    bus_wr(0, 2'd3, 32'h1);
    check("t2_irq_after_clear", {31'b0, irq_a}, 32'h0);
    rd_chk(0, 2'd3, 32'h0, "t2_edgecap_cleared");

    // 3: a 3-cycle glitch on bit 1 is rejected, a 4-cycle pulse is not.
    pin_a = 2'b11;
    idle(3);
    pin_a = 2'b01;
    idle(8);
    rd_chk(0, 2'd0, 32'h1, "t3_data_glitch");
    rd_chk(0, 2'd3, 32'h0, "t3_edgecap_glitch");
    check("t3_irq_glitch", {31'b0, irq_a}, 32'h0);
    pin_a = 2'b11;
    idle(4);
    pin_a = 2'b01;
    idle(8);
    rd_chk(0, 2'd3, 32'h2, "t3_edgecap_pulse");
    check("t3_irq_unmasked_bit", {31'b0, irq_a}, 32'h0);
    bus_wr(0, 2'd3, 32'h2);

    // 4: capture and clear on the same edge -> capture wins.
    pin_a = 2'b00;
    idle(8);
    pin_a = 2'b01;
    idle(6);
    bus_wr(0, 2'd3, 32'h1);
    rd_chk(0, 2'd3, 32'h1, "t4_capture_wins");
    check("t4_irq", {31'b0, irq_a}, 32'h1);
    bus_wr(0, 2'd3, 32'h1);

    // 5: instance B, any edge, no debounce: capture 3 edges after each change.
    pin_b = 2'b01;
    idle(2);
    rd_chk(1, 2'd3, 32'h0, "t5_rise_not_yet");
    rd_chk(1, 2'd3, 32'h1, "t5_rise_captured");
    bus_wr(1, 2'd3, 32'h1);
    pin_b = 2'b00;
    rd_chk(1, 2'd3, 32'h0, "t5_cleared");
    idle(2);
    rd_chk(1, 2'd3, 32'h1, "t5_fall_captured");
    rd_chk(1, 2'd0, 32'h0, "t5_data");

    // 6: reset mid-debounce clears everything; DATA/address 1 ignore writes.
    bus_wr(0, 2'd2, 32'h3);
    pin_a = 2'b11;
    idle(7);
    check("t6_irq_set", {31'b0, irq_a}, 32'h1);
    rd_chk(0, 2'd3, 32'h2, "t6_edgecap_pre");
    pin_a = 2'b01;
    idle(3);
    reset = 1'b1;
    cycle();
    check("t6_reset_readdata", bus_a.readdata, 32'h0);
    check("t6_reset_irq", {31'b0, irq_a}, 32'h0);
    reset = 1'b0;
    rd_chk(0, 2'd2, 32'h0, "t6_irqmask");
    rd_chk(0, 2'd3, 32'h0, "t6_edgecap");
    rd_chk(0, 2'd1, 32'h0, "t6_addr1");
    idle(10);
    rd_chk(0, 2'd0, 32'h1, "t6_data");
    bus_wr(0, 2'd0, 32'hFFFF_FFFF);
    bus_wr(0, 2'd1, 32'hFFFF_FFFF);
    rd_chk(0, 2'd0, 32'h1, "t6_data_after_write");
    rd_chk(0, 2'd1, 32'h0, "t6_addr1_after_write");

    // Randomised traffic on both instances, including overlapping
    // read/write and occasional resets, checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(399) == 0);
      for (int b = 0; b < 2; b++) begin
        if ($urandom_range(7) == 0) pin_a[b] = ~pin_a[b];
        if ($urandom_range(7) == 0) pin_b[b] = ~pin_b[b];
      end
      for (int u = 0; u < 2; u++) begin
        cs_v[u]   = 1'($urandom_range(1));
        rn_v[u]   = 1'($urandom_range(1));
        wn_v[u]   = ($urandom_range(3) != 0);
        addr_v[u] = 2'($urandom_range(3));
        wd_v[u]   = $urandom;
      end
      cycle();
    end
    reset = 1'b0;
    for (int u = 0; u < 2; u++) begin
      cs_v[u] = 1'b0; rn_v[u] = 1'b1; wn_v[u] = 1'b1;
    end
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
